uart_mmr: RTL and testbench
===========================

Name: uart_mmr

Overview:
- Memory-mapped UART responder for the UART window (0x1000_0000–0x1000_00FF); the core's LSU is the initiator.
- Serialises bytes written to TXDATA onto uart_tx_o as 8N1 frames.
- Deserialises 8N1 frames from uart_rx_i into a receive FIFO, drained by reads of RXDATA.
- Exposes FIFO and error state through STATUS.

Parameters:
- CLKS_PER_BIT, CLK_FREQ/115200, clock cycles per serial bit; must be ≥4.
- FIFO_DEPTH, 4, entries in each of the TX and RX FIFOs; power of two ≥2.

Ports:
- clk  in  1  core clock
- rst  in  1  reset, synchronous, active-high
- req_i  in  1  bus request, valid for one cycle
- we_i  in  1  1=write, 0=read
- addr_i  in  32  byte address; only addr_i[7:0] decoded
- wdata_i  in  32  write data
- be_i  in  4  byte enables
- rsp_o  out  1  response strobe, one cycle after req_i
- rdata_o  out  32  read data, valid with rsp_o
- uart_tx_o  out  1  serial out, idle high
- uart_rx_i  in  1  serial in, asynchronous
- irq_o  out  1  level, high while RX FIFO non-empty

Behaviour:
- Clocking/reset: one clock; reset is synchronous and active-high.
- Reset values: rsp_o=0, rdata_o=0, uart_tx_o=1, irq_o=0. Both FIFOs empty, sticky flags cleared, both FSMs idle.
- Reset mid-frame aborts immediately; uart_tx_o returns to 1 in the cycle after rst.
- Bus timing: every req_i gets rsp_o=1 exactly one cycle later, with no stalls. rdata_o is registered and is 0 on writes.
- Decode on addr_i[7:0]:
  - 0x00 TXDATA
  - 0x04 RXDATA
  - 0x08 STATUS
  - all other offsets: read 0, writes ignored, no side effects.
- TXDATA write with be_i[0]=1: pushes wdata_i[7:0]. If the TX FIFO is full, the byte is silently dropped. be_i[0]=0 means no push.
- TXDATA read: returns {tx_full, 31'b0}.
- RXDATA read:
  - non-empty: returns {1'b0, 23'b0, head}; pop in the request cycle.
  - empty: returns 32'h8000_0000; no pop.
- STATUS read returns {27'b0, frame_err, overrun, rx_valid, tx_empty, tx_full}:
  - bit0 tx_full: TX FIFO full.
  - bit1 tx_empty: TX FIFO empty and TX FSM idle.
  - bit2 rx_valid: RX FIFO non-empty.
  - bit3 overrun and bit4 frame_err: sticky; reads return the pre-clear value, then both clear. A set in the same cycle as the read wins.
- STATUS writes are ignored.
- TX FSM (IDLE, START, DATA, STOP):
  - IDLE→START when the FIFO is non-empty: pop and load the shifter; uart_tx_o=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits LSB-first, CLKS_PER_BIT each.
  - STOP: uart_tx_o=1 for CLKS_PER_BIT cycles.
  - From STOP, go to START directly if the FIFO is non-empty (back-to-back frames, no idle gap); else go to IDLE.
  - A frame in progress is never disturbed by FIFO pushes.
- RX input: 2-flop synchroniser on uart_rx_i. All RX timing is referenced to the synchronised signal.
- RX FSM (IDLE, START, DATA, STOP):
  - IDLE→START on the synchronised falling edge.
  - START: at CLKS_PER_BIT/2, resample; if high (glitch), go to IDLE; else go to DATA.
  - DATA: sample every CLKS_PER_BIT, LSB-first, 8 bits.
  - STOP: sample one CLKS_PER_BIT later. If 1, push the byte; if 0, discard it and set frame_err. Return to IDLE after the stop-bit sample, not at its end.
- RX push vs pop:
  - Push when the FIFO is full and no pop occurs in that cycle: byte dropped, overrun set.
  - Simultaneous pop and push on a full FIFO: both succeed; occupancy unchanged.
- FIFOs: circular buffers with read/write pointers of width $clog2(FIFO_DEPTH)+1. Full/empty are derived from the pointer MSB; pointers wrap modulo 2·FIFO_DEPTH.
- irq_o is registered and equals rx_valid, delayed one cycle from the FIFO state.

Decomposition:
- Shared package additions:
  - uart_tx_state_t and uart_rx_state_t enums {IDLE, START, DATA, STOP}.
  - Register offset constants UART_OFS_TXDATA=8'h00, UART_OFS_RXDATA=8'h04, UART_OFS_STATUS=8'h08.
  - STATUS bit index constants.
  - UART_BAUD=115200 beside CLK_FREQ.
- The existing UART_MMR_ADDR_* enums remain the absolute addresses.
- Sub-module uart_fifo (WIDTH, DEPTH; push, pop, din, dout, full, empty), instantiated twice.

Test Plan:
(Bench overrides: CLKS_PER_BIT=8, FIFO_DEPTH=4.)
- Reset, then read STATUS → rdata_o=32'h0000_0002 one cycle after req, with uart_tx_o=1.
- Write TXDATA 0x0000_00A5 → uart_tx_o, starting 1–2 cycles later: 0 for 8 cycles, then bits 1,0,1,0,0,1,0,1 at 8 cycles each, then 1. STATUS bit1 returns to 1 after the stop bit.
- Write TXDATA 6 times back-to-back (0x11–0x16) → frames 0x11–0x15 transmitted contiguously with no idle gap; 0x16 dropped. STATUS bit0=1 after the 5th write.
- Drive 8N1 frame 0x3C on uart_rx_i → irq_o=1 afterwards. RXDATA read returns 0x0000_003C; a second read returns 0x8000_0000 and irq_o drops.
- Drive 5 valid frames with no reads → first 4 bytes retained, STATUS=0x0000_000E (overrun set, tx_empty set). The next STATUS read returns 0x0000_0006.
- Drive a frame with stop bit 0 → no push, STATUS bit4=1. A 2-cycle low glitch on uart_rx_i → no frame and no flags.

Source files
------------

// File: rtl/uart_mmr_pkg.sv
// Shared constants and types for the memory-mapped UART: clocking, register map,
// STATUS bit positions and the TX/RX state encodings.
package uart_mmr_pkg;

  localparam int unsigned CLK_FREQ          = 50_000_000;
  localparam int unsigned UART_BAUD         = 115_200;
  localparam int unsigned UART_CLKS_PER_BIT = CLK_FREQ / UART_BAUD;

  // Absolute addresses of the registers inside the UART window
  typedef enum logic [31:0] {
    UART_MMR_ADDR_TXDATA = 32'h1000_0000,
    UART_MMR_ADDR_RXDATA = 32'h1000_0004,
    UART_MMR_ADDR_STATUS = 32'h1000_0008
  } uart_mmr_addr_e;

  localparam logic [7:0] UART_OFS_TXDATA = 8'h00;
  localparam logic [7:0] UART_OFS_RXDATA = 8'h04;
  localparam logic [7:0] UART_OFS_STATUS = 8'h08;

  localparam int STAT_TX_FULL   = 0;
  localparam int STAT_TX_EMPTY  = 1;
  localparam int STAT_RX_VALID  = 2;
  localparam int STAT_OVERRUN   = 3;
  localparam int STAT_FRAME_ERR = 4;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} uart_tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} uart_rx_state_t;

endpackage

// File: rtl/uart_fifo.sv
// Circular-buffer FIFO with one extra pointer bit to tell full from empty.
// A pop and a push in the same cycle on a full FIFO both succeed.
module uart_fifo
  import uart_mmr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/uart_mmr.sv
// Memory-mapped 8N1 UART: single-cycle bus responder, TX serialiser and RX
// deserialiser, each backed by a small FIFO.
module uart_mmr
  import uart_mmr_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  be_i,
  output logic        rsp_o,
  output logic [31:0] rdata_o,
  output logic        uart_tx_o,
  input  logic        uart_rx_i,
  output logic        irq_o
);

  localparam int             CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]  HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  logic unused_bus;
  assign unused_bus = ^{addr_i[31:8], wdata_i[31:8], be_i[3:1]};

  // Bus decode
  logic [7:0] ofs;
  logic       bus_rd, bus_wr, stat_rd;
  logic       tx_push, tx_pop, rx_push, rx_pop;
  logic       tx_full, tx_fifo_empty, tx_empty, rx_full, rx_empty;
  logic [7:0] tx_dout, rx_dout;

  assign ofs     = addr_i[7:0];
  assign bus_rd  = req_i && !we_i;
  assign bus_wr  = req_i && we_i;
  assign stat_rd = bus_rd && (ofs == UART_OFS_STATUS);
  assign tx_push = bus_wr && (ofs == UART_OFS_TXDATA) && be_i[0] && !tx_full;
  assign rx_pop  = bus_rd && (ofs == UART_OFS_RXDATA) && !rx_empty;

  // TX path
  uart_tx_state_t tx_st_q;
  logic [CW-1:0]  tx_cnt_q;
  logic [2:0]     tx_bit_q;
  logic [7:0]     tx_sh_q;
  logic           tx_q;

  uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (tx_push),
    .pop_i   (tx_pop),
    .din_i   (wdata_i[7:0]),
    .dout_o  (tx_dout),
    .full_o  (tx_full),
    .empty_o (tx_fifo_empty)
  );

  // A new frame starts from IDLE or straight out of the last stop-bit cycle
  assign tx_pop   = ((tx_st_q == TX_IDLE) ||
                     (tx_st_q == TX_STOP && tx_cnt_q == BIT_LAST)) && !tx_fifo_empty;
  assign tx_empty = tx_fifo_empty && (tx_st_q == TX_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_st_q  <= TX_IDLE;
      tx_cnt_q <= '0;
      tx_bit_q <= '0;
      tx_sh_q  <= '0;
      tx_q     <= 1'b1;
    end else begin
      case (tx_st_q)
        TX_IDLE: if (tx_pop) begin
          tx_st_q  <= TX_START;
          tx_sh_q  <= tx_dout;
          tx_cnt_q <= '0;
          tx_q     <= 1'b0;
        end
        TX_START: if (tx_cnt_q == BIT_LAST) begin
          tx_st_q  <= TX_DATA;
          tx_cnt_q <= '0;
          tx_bit_q <= '0;
          tx_q     <= tx_sh_q[0];
        end else begin
          tx_cnt_q <= tx_cnt_q + CW'(1);
        end
        TX_DATA: if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_q <= '0;
          if (tx_bit_q == 3'd7) begin
            tx_st_q <= TX_STOP;
            tx_q    <= 1'b1;
          end else begin
            tx_bit_q <= tx_bit_q + 3'd1;
            tx_sh_q  <= {1'b0, tx_sh_q[7:1]};
            tx_q     <= tx_sh_q[1];
          end
        end else begin
          tx_cnt_q <= tx_cnt_q + CW'(1);
        end
        TX_STOP: if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_q <= '0;
          if (tx_pop) begin
            tx_st_q <= TX_START;
            tx_sh_q <= tx_dout;
            tx_q    <= 1'b0;
          end else begin
            tx_st_q <= TX_IDLE;
          end
        end else begin
          tx_cnt_q <= tx_cnt_q + CW'(1);
        end
        default: tx_st_q <= TX_IDLE;
      endcase
    end
  end

  // RX path: synchroniser plus one more flop for edge detection
  uart_rx_state_t rx_st_q;
  logic [CW-1:0]  rx_cnt_q;
  logic [2:0]     rx_bit_q;
  logic [7:0]     rx_sh_q;
  logic           rx_s1_q, rx_s2_q, rx_prev_q;
  logic           rx_fall, rx_stop_smp, fe_set, ovr_set;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= uart_rx_i;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  assign rx_fall     = rx_prev_q && !rx_s2_q;
  assign rx_stop_smp = (rx_st_q == RX_STOP) && (rx_cnt_q == BIT_LAST);
  assign rx_push     = rx_stop_smp && rx_s2_q;
  assign fe_set      = rx_stop_smp && !rx_s2_q;
  assign ovr_set     = rx_push && rx_full && !rx_pop;

  uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (rx_push),
    .pop_i   (rx_pop),
    .din_i   (rx_sh_q),
    .dout_o  (rx_dout),
    .full_o  (rx_full),
    .empty_o (rx_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_st_q  <= RX_IDLE;
      rx_cnt_q <= '0;
      rx_bit_q <= '0;
      rx_sh_q  <= '0;
    end else begin
      case (rx_st_q)
        RX_IDLE: if (rx_fall) begin
          rx_st_q  <= RX_START;
          rx_cnt_q <= '0;
        end
        RX_START: if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_q <= '0;
          rx_bit_q <= '0;
          rx_st_q  <= rx_s2_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_q <= rx_cnt_q + CW'(1);
        end
        RX_DATA: if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_q <= '0;
          rx_sh_q  <= {rx_s2_q, rx_sh_q[7:1]};
          if (rx_bit_q == 3'd7) rx_st_q <= RX_STOP;
          else                  rx_bit_q <= rx_bit_q + 3'd1;
        end else begin
          rx_cnt_q <= rx_cnt_q + CW'(1);
        end
        // Back to IDLE right at the stop sample so the next start edge is caught early
        RX_STOP: if (rx_stop_smp) begin
          rx_cnt_q <= '0;
          rx_st_q  <= RX_IDLE;
        end else begin
          rx_cnt_q <= rx_cnt_q + CW'(1);
        end
        default: rx_st_q <= RX_IDLE;
      endcase
    end
  end

  // Register file and response
  logic        rsp_q, irq_q, overrun_q, frame_err_q;
  logic        overrun_d, frame_err_d;
  logic [31:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = '0;
    if (bus_rd) begin
      case (ofs)
        UART_OFS_TXDATA: rdata_d[31] = tx_full;
        UART_OFS_RXDATA: rdata_d = rx_empty ? 32'h8000_0000 : {24'b0, rx_dout};
        UART_OFS_STATUS: begin
          rdata_d[STAT_TX_FULL]   = tx_full;
          rdata_d[STAT_TX_EMPTY]  = tx_empty;
          rdata_d[STAT_RX_VALID]  = !rx_empty;
          rdata_d[STAT_OVERRUN]   = overrun_q;
          rdata_d[STAT_FRAME_ERR] = frame_err_q;
        end
        default: rdata_d = '0;
      endcase
    end
  end

  // Read-to-clear, but a new event in the same cycle survives the clear
  assign overrun_d   = (overrun_q && !stat_rd) || ovr_set;
  assign frame_err_d = (frame_err_q && !stat_rd) || fe_set;

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_q       <= 1'b0;
      rdata_q     <= '0;
      irq_q       <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rsp_q       <= req_i;
      rdata_q     <= rdata_d;
      irq_q       <= !rx_empty;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign rsp_o     = rsp_q;
  assign rdata_o   = rdata_q;
  assign irq_o     = irq_q;
  assign uart_tx_o = tx_q;

endmodule

// File: tb/tb_uart_mmr.sv
// Directed bench for uart_mmr: queue-based register/FIFO model, a bus response
// checker and a serial TX frame monitor, plus literal expectations.
module tb_uart_mmr;

  localparam int CPB   = 8;
  localparam int DEPTH = 4;
  localparam logic [31:0] A_TX = 32'h1000_0000;
  localparam logic [31:0] A_RX = 32'h1000_0004;
  localparam logic [31:0] A_ST = 32'h1000_0008;

  logic        clk = 1'b0, rst = 1'b1, req_i = 1'b0, we_i = 1'b0, uart_rx_i = 1'b1;
  logic [31:0] addr_i = '0, wdata_i = '0;
  logic [3:0]  be_i = '0;
  logic        rsp_o, uart_tx_o, irq_o;
  logic [31:0] rdata_o;

  always #5 clk = ~clk;

  uart_mmr #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .be_i(be_i), .rsp_o(rsp_o), .rdata_o(rdata_o),
    .uart_tx_o(uart_tx_o), .uart_rx_i(uart_rx_i), .irq_o(irq_o)
  );

  int checks = 0, errors = 0, mon_frames = 0;

  typedef struct { logic [31:0] v; bit has_lit; logic [31:0] lit; } exp_t;
  exp_t       exp_q[$];
  logic [7:0] txm_q[$], rxm_q[$];
  bit         m_ovr, m_fe, mon_busy, gap_chk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", n, act, exp, $time);
    end
  endtask

  // Register-level model of one bus access, evaluated in the request cycle
  task automatic model(input bit we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be, output logic [31:0] r);
    r = '0;
    case (a[7:0])
      8'h00: if (we) begin
               if (be[0] && txm_q.size() < DEPTH) txm_q.push_back(wd[7:0]);
             end else r = {(txm_q.size() == DEPTH), 31'b0};
      8'h04: if (!we) r = (rxm_q.size() > 0) ? {24'b0, rxm_q.pop_front()} : 32'h8000_0000;
      8'h08: if (!we) begin
               r = {27'b0, m_fe, m_ovr, (rxm_q.size() != 0),
                    (txm_q.size() == 0 && !mon_busy), (txm_q.size() == DEPTH)};
               m_fe  = 1'b0;
               m_ovr = 1'b0;
             end
      default: r = '0;
    endcase
  endtask

  // Called just after a negedge; leaves the bus idle at the next negedge
  task automatic bus(input bit we, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] be, input bit hl, input logic [31:0] lit);
    exp_t e;
    req_i = 1'b1; we_i = we; addr_i = a; wdata_i = wd; be_i = be;
    model(we, a, wd, be, e.v);
    e.has_lit = hl;
    e.lit     = lit;
    exp_q.push_back(e);
    @(negedge clk);
    req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0; be_i = '0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    bus(1'b1, a, d, be, 1'b0, '0);
  endtask

  task automatic rdl(input logic [31:0] a, input logic [31:0] lit);
    bus(1'b0, a, '0, '0, 1'b1, lit);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    txm_q.delete(); rxm_q.delete(); exp_q.delete();
    m_ovr = 1'b0; m_fe = 1'b0; mon_busy = 1'b0;
    rst = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b, input bit stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx_i = fr[i];
      repeat (CPB) @(negedge clk);
    end
    if (stop) begin
      if (rxm_q.size() < DEPTH) rxm_q.push_back(b);
      else m_ovr = 1'b1;
    end else m_fe = 1'b1;
    uart_rx_i = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  // Bus response checker
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rsp", rsp_o, 1);
        chk("rdata", rdata_o, e.v);
        if (e.has_lit) chk("rdata_lit", rdata_o, e.lit);
      end else chk("rsp_idle", rsp_o, 0);
    end
  end

  // Serial TX monitor: one frame = 10*CPB samples
  initial begin
    logic [7:0] got, expb;
    logic       rf;
    bit         ok, aborted;
    int         s;
    forever begin
      @(posedge clk); #1;
      if (rst) begin gap_chk = 1'b0; continue; end
      if (gap_chk) begin chk("tx_gap", uart_tx_o, 0); gap_chk = 1'b0; end
      if (uart_tx_o === 1'b0) begin
        mon_busy = 1'b1; ok = 1'b1; aborted = 1'b0; got = '0; expb = '0;
        if (txm_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL tx_unexpected frame start at %0t", $time);
        end else expb = txm_q.pop_front();
        for (int i = 1; i < 10 * CPB; i++) begin
          @(posedge clk); #1;
          if (rst) begin aborted = 1'b1; break; end
          s = i / CPB;
          if (i % CPB == 0 && s >= 1 && s <= 8) got[s-1] = uart_tx_o;
          rf = (s == 0) ? 1'b0 : (s == 9) ? 1'b1 : got[s-1];
          if (uart_tx_o !== rf) ok = 1'b0;
        end
        if (!aborted) begin
          chk("tx_frame_shape", ok, 1);
          chk("tx_byte", got, expb);
          mon_frames++;
          gap_chk = (txm_q.size() > 0);
        end
        mon_busy = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    chk("rst_rsp", rsp_o, 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_tx", uart_tx_o, 1);
    chk("rst_irq", irq_o, 0);
    rdl(A_ST, 32'h0000_0002);
    chk("idle_tx", uart_tx_o, 1);

    // Decode boundaries: aliasing above bit 7, unmapped offsets, ignored writes
    rdl(32'h1000_0108, 32'h0000_0002);
    rdl(32'h1000_000C, 32'h0000_0000);
    wr(32'h1000_000C, 32'h0000_00FF, 4'hF);
    wr(A_ST, 32'h0000_001F, 4'hF);
    wr(A_TX, 32'h0000_0077, 4'b1110);
    rdl(A_RX, 32'h8000_0000);
    idle(4);
    rdl(A_ST, 32'h0000_0002);

    // Single frame 0xA5
    wr(A_TX, 32'h0000_00A5, 4'b0001);
    idle(20);
    rdl(A_ST, 32'h0000_0000);
    idle(80);
    rdl(A_ST, 32'h0000_0002);
    chk("tx_frames_a5", mon_frames, 1);

    // Six back-to-back writes: five contiguous frames, last byte dropped
    for (int i = 0; i < 6; i++) wr(A_TX, 32'h11 + i, 4'b0001);
    rdl(A_ST, 32'h0000_0001);
    rdl(A_TX, 32'h8000_0000);
    idle(5 * 10 * CPB + 20);
    rdl(A_ST, 32'h0000_0002);
    chk("tx_frames_burst", mon_frames, 6);

    // Receive one frame
    send_rx(8'h3C, 1'b1);
    chk("irq_set", irq_o, 1);
    rdl(A_RX, 32'h0000_003C);
    rdl(A_RX, 32'h8000_0000);
    idle(3);
    chk("irq_clr", irq_o, 0);

    // Overrun: five frames into a four-deep FIFO
    for (int i = 1; i <= 5; i++) send_rx(8'(i), 1'b1);
    rdl(A_ST, 32'h0000_000E);
    rdl(A_ST, 32'h0000_0006);
    for (int i = 1; i <= 4; i++) rdl(A_RX, 32'(i));
    rdl(A_RX, 32'h8000_0000);

    // Framing error, then a short glitch
    send_rx(8'h5A, 1'b0);
    rdl(A_ST, 32'h0000_0012);
    rdl(A_ST, 32'h0000_0002);
    rdl(A_RX, 32'h8000_0000);
    uart_rx_i = 1'b0;
    idle(2);
    uart_rx_i = 1'b1;
    idle(3 * CPB);
    rdl(A_ST, 32'h0000_0002);
    chk("glitch_irq", irq_o, 0);

    // Reset in the middle of a frame
    wr(A_TX, 32'h0000_0000, 4'b0001);
    idle(20);
    chk("midframe_tx", uart_tx_o, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_abort_tx", uart_tx_o, 1);
    do_reset();
    idle(2);
    rdl(A_ST, 32'h0000_0002);
    idle(2 * 10 * CPB);
    chk("tx_frames_final", mon_frames, 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
